msx_slot_config: RTL and testbench
==================================

Name: msx_slot_config

Overview:
- Parametrised successor of the two-slot cartridge configuration decoder.
- Decodes OSD selections for SLOTS cartridge slots into cartridge type, mapper and SRAM size.
- Filters OSD changes through a stability (settle) window, then raises a reload request held until the core acknowledges it.
- Sits between the HPS status decode and the cartridge/slot-expander logic.

Parameters:
- SLOTS, 2: number of cartridge slots, 1..4.
- EXT_MASK, 4'b0001: bit i=1 means slot i accepts extended types (MFRSD, GM2, FDC); otherwise only ROM/SCC/SCC+/FM-PAC are valid and anything else maps to EMPTY.
- SRAM_MASK, 4'b0001: bit i=1 means slot i supports a selectable SRAM size; otherwise its size is 0.
- SETTLE_CYCLES, 1024: consecutive stable cycles required before reload; legal range ≥1.
- CNT_W, 11: settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- use_fdc  in  1  BIOS configuration provides an internal FDC
- slot_select  in  3*SLOTS  per-slot type select; slot i occupies bits [3i+2:3i]
- mapper_select  in  4*SLOTS  per-slot mapper select
- sram_select  in  3*SLOTS  per-slot SRAM select
- reload_ack  in  1  core has consumed the current configuration
- cart_typ  out  3*SLOTS  decoded type: 0 ROM, 1 SCC, 2 SCC+, 3 FM-PAC, 4 MFRSD, 5 GM2, 6 FDC, 7 EMPTY
- cart_mapper  out  4*SLOTS  mapper_select+2, modulo 16
- cart_sram_size  out  8*SLOTS  SRAM size in kB
- rom_load_hide  out  SLOTS  bit i = (cart_typ[i] != ROM)
- sram_select_hide  out  SLOTS  bit i = ~SRAM_MASK[i] | typ != ROM | mapper_select == 0
- fdc_enabled  out  1  use_fdc | any slot decodes to FDC
- reload  out  1  registered reload request
- changed_slots  out  SLOTS  see Optional Feature

Behaviour:
- Decode is combinational from the inputs.
- Type, extended slot: sel<6 → sel; sel==6 and ~use_fdc → FDC; otherwise EMPTY.
- Type, non-extended slot: sel<4 → sel; otherwise EMPTY.
- SRAM size: if SRAM_MASK[i] & typ==ROM & mapper_select>1 & 1≤sram_select≤6, size = 8'd1<<(sram_select-1); otherwise 0.
- act_cfg: concatenation per slot of {typ, mapper, raw sram_select}, 10 bits per slot. Registers snap and cand hold copies of it.
- FSM states: INIT, IDLE, SETTLE, RELOAD.
- Reset (async): state=INIT, reload=0, cnt=0, changed_slots=0; snap and cand cleared.
- INIT: next edge snap<=act_cfg, go to IDLE. No reload is issued for the power-on configuration.
- IDLE: when act_cfg!=snap → cand<=act_cfg, cnt<=0, go to SETTLE.
- SETTLE: when act_cfg!=cand → cand<=act_cfg, cnt<=0 (restart window). Otherwise:
  - if cnt==SETTLE_CYCLES-1 → snap<=cand, reload<=1, go to RELOAD;
  - else cnt<=cnt+1.
- SETTLE returning to the original value: if cand==snap when the window expires, go to IDLE with no reload.
- Latency: an input change that is stable from edge k produces reload high after edge k+1+SETTLE_CYCLES.
- RELOAD: reload stays high until reload_ack is sampled high; that edge sets reload<=0 and goes to IDLE. Input changes during RELOAD are ignored; they are detected in IDLE on the following edge.
- reload_ack outside RELOAD is ignored.
- Reset mid-SETTLE or mid-RELOAD: reload drops immediately, FSM returns to INIT, and the pending change is absorbed as the new baseline.

Optional Feature:
- Macro MSX_SLOT_CHANGE_MASK_EN.
- Defined: when entering RELOAD, changed_slots bit i is registered = (slot i field of cand != slot i field of old snap). It holds until RELOAD exits, then clears to 0.
- Undefined: changed_slots = {SLOTS{reload}}.

Test Plan:
- Reset with slot_select=0 (ROM, all slots), release, hold 2000 cycles → reload stays 0; cart_typ=ROM; rom_load_hide=0.
- SETTLE_CYCLES=4: set slot1 select from 0 to 1 at edge k → reload=1 after edge k+5. Assert ack one cycle later → reload=0 next edge.
- Toggle slot0 select every 3 cycles with SETTLE_CYCLES=4 → no reload. Stop toggling → exactly one reload, 5 cycles after the last change.
- slot0 sel=6: with use_fdc=1 → typ=EMPTY, fdc_enabled=1; with use_fdc=0 → typ=FDC. Slot1 sel=4 → EMPTY.
- slot0 ROM, mapper_select=2, sram_select=3 → size 4; mapper_select=1 → size 0, sram_select_hide=0; mapper_select=0 → hide=1; mapper_select=15 → cart_mapper=1.
- With MSX_SLOT_CHANGE_MASK_EN: change only slot1 → changed_slots=2'b10 during reload. Assert reset while reload=1 → reload=0 immediately, and no reload follows.

Source files
------------

// File: rtl/msx_slot_config_if.sv
// msx_slot_config_if: OSD selections in, decoded cartridge config out,
// plus the reload/reload_ack handshake towards the core.
interface msx_slot_config_if #(
   parameter int SLOTS = 2
);
   logic                 use_fdc;
   logic [3*SLOTS-1:0]   slot_select;
   logic [4*SLOTS-1:0]   mapper_select;
   logic [3*SLOTS-1:0]   sram_select;
   logic                 reload_ack;
   logic [3*SLOTS-1:0]   cart_typ;
   logic [4*SLOTS-1:0]   cart_mapper;
   logic [8*SLOTS-1:0]   cart_sram_size;
   logic [SLOTS-1:0]     rom_load_hide;
   logic [SLOTS-1:0]     sram_select_hide;
   logic                 fdc_enabled;
   logic                 reload;
   logic [SLOTS-1:0]     changed_slots;

   modport master (
      output use_fdc, slot_select, mapper_select,
      output sram_select, reload_ack,
      input  cart_typ, cart_mapper, cart_sram_size,
      input  rom_load_hide, sram_select_hide,
      input  fdc_enabled, reload, changed_slots
   );

   modport slave (
      input  use_fdc, slot_select, mapper_select,
      input  sram_select, reload_ack,
      output cart_typ, cart_mapper, cart_sram_size,
      output rom_load_hide, sram_select_hide,
      output fdc_enabled, reload, changed_slots
   );
endinterface

// File: rtl/msx_slot_config.sv
// msx_slot_config: per-slot cartridge decode with settle-filtered reload.
// Optional MSX_SLOT_CHANGE_MASK_EN: registered per-slot change mask.
module msx_slot_config #(
   parameter int         SLOTS         = 2,
   parameter logic [3:0] EXT_MASK      = 4'b0001,
   parameter logic [3:0] SRAM_MASK     = 4'b0001,
   parameter int         SETTLE_CYCLES = 1024,
   parameter int         CNT_W         = 11
) (
   input  logic             clk,
   input  logic             reset,
   msx_slot_config_if.slave bus
);
   localparam int CW = 10 * SLOTS;
   localparam logic [2:0] T_ROM   = 3'd0;
   localparam logic [2:0] T_FDC   = 3'd6;
   localparam logic [2:0] T_EMPTY = 3'd7;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      INIT, IDLE, SETTLE, RELOAD
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [CW-1:0]      act_cfg;
   logic [CW-1:0]      snap;
   logic [CW-1:0]      cand;
   logic [3*SLOTS-1:0] typ;
   logic [4*SLOTS-1:0] mapper;
   logic [8*SLOTS-1:0] size;
   logic [SLOTS-1:0]   rom_hide;
   logic [SLOTS-1:0]   sram_hide;
   logic               any_fdc;
   logic               reload_q;
   logic [SLOTS-1:0]   diff;

   function automatic logic [2:0] dec_typ(
      input logic [2:0] sel,
      input logic       ext,
      input logic       fdc_int
   );
      logic [2:0] t;
      t = T_EMPTY;
      if (ext) begin
         if (sel < 3'd6)
            t = sel;
         else if (sel == 3'd6 && !fdc_int)
            t = T_FDC;
      end else if (sel < 3'd4) begin
         t = sel;
      end
      return t;
   endfunction

   // Per-slot decode of type, mapper, SRAM size and hide flags.
   always_comb begin
      typ       = '0;
      mapper    = '0;
      size      = '0;
      rom_hide  = '0;
      sram_hide = '0;
      any_fdc   = 1'b0;
      act_cfg   = '0;
      for (int i = 0; i < SLOTS; i++) begin
         typ[3*i +: 3] = dec_typ(bus.slot_select[3*i +: 3],
                                 EXT_MASK[i], bus.use_fdc);
         mapper[4*i +: 4] = bus.mapper_select[4*i +: 4] + 4'd2;
         rom_hide[i] = typ[3*i +: 3] != T_ROM;
         sram_hide[i] = !SRAM_MASK[i]
                     || typ[3*i +: 3] != T_ROM
                     || bus.mapper_select[4*i +: 4] == 4'd0;
         if (SRAM_MASK[i]
             && typ[3*i +: 3] == T_ROM
             && bus.mapper_select[4*i +: 4] > 4'd1
             && bus.sram_select[3*i +: 3] != 3'd0
             && bus.sram_select[3*i +: 3] != 3'd7)
            size[8*i +: 8] =
               8'd1 << (bus.sram_select[3*i +: 3] - 3'd1);
         any_fdc = any_fdc | (typ[3*i +: 3] == T_FDC);
         act_cfg[10*i +: 10] = {typ[3*i +: 3], mapper[4*i +: 4],
                                bus.sram_select[3*i +: 3]};
      end
   end

   // Which slots differ between the pending and published configs.
   always_comb begin
      diff = '0;
      for (int i = 0; i < SLOTS; i++)
         diff[i] = cand[10*i +: 10] != snap[10*i +: 10];
   end

`ifdef MSX_SLOT_CHANGE_MASK_EN
   logic [SLOTS-1:0] chg_q;
`endif

   // Settle filter and reload handshake; snap is the published config.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= INIT;
         reload_q <= 1'b0;
         cnt      <= '0;
         snap     <= '0;
         cand     <= '0;
`ifdef MSX_SLOT_CHANGE_MASK_EN
         chg_q    <= '0;
`endif
      end else begin
         unique case (state)
            INIT: begin
               snap  <= act_cfg;
               state <= IDLE;
            end
            IDLE: begin
               if (act_cfg != snap) begin
                  cand  <= act_cfg;
                  cnt   <= '0;
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if (act_cfg != cand) begin
                  cand <= act_cfg;
                  cnt  <= '0;
               end else if (cnt == CNT_LAST) begin
                  if (cand == snap) begin
                     state <= IDLE;
                  end else begin
                     snap     <= cand;
                     reload_q <= 1'b1;
                     state    <= RELOAD;
`ifdef MSX_SLOT_CHANGE_MASK_EN
                     chg_q    <= diff;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RELOAD: begin
               if (bus.reload_ack) begin
                  reload_q <= 1'b0;
                  state    <= IDLE;
`ifdef MSX_SLOT_CHANGE_MASK_EN
                  chg_q    <= '0;
`endif
               end
            end
            default: state <= INIT;
         endcase
      end
   end

`ifdef MSX_SLOT_CHANGE_MASK_EN
   assign bus.changed_slots = chg_q;
`else
   logic unused_diff;
   assign unused_diff = ^diff;
   assign bus.changed_slots = {SLOTS{reload_q}};
`endif

   assign bus.cart_typ         = typ;
   assign bus.cart_mapper      = mapper;
   assign bus.cart_sram_size   = size;
   assign bus.rom_load_hide    = rom_hide;
   assign bus.sram_select_hide = sram_hide;
   assign bus.fdc_enabled      = bus.use_fdc | any_fdc;
   assign bus.reload           = reload_q;
endmodule

// File: tb/tb_msx_slot_config.sv
// tb_msx_slot_config: decode table and reload timing checks,
// with expectations queued at stimulus time and popped on output.
module tb_msx_slot_config;
   localparam int SLOTS = 2;

`ifdef MSX_SLOT_CHANGE_MASK_EN
   localparam logic [1:0] CHG_S1 = 2'b10;
`else
   localparam logic [1:0] CHG_S1 = 2'b11;
`endif

   typedef struct packed {
      logic       f;
      logic [2:0] s0;
      logic [2:0] s1;
      logic [3:0] m0;
      logic [2:0] r0;
      logic [5:0] typ;
      logic [7:0] map;
      logic [15:0] size;
      logic [1:0] rh;
      logic [1:0] sh;
      logic       fdc;
   } dec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   dec_t dec_q[$];
   int   cyc_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   msx_slot_config_if #(.SLOTS(SLOTS)) bif ();

   msx_slot_config #(
      .SLOTS(SLOTS),
      .EXT_MASK(4'b0001),
      .SRAM_MASK(4'b0001),
      .SETTLE_CYCLES(4),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bif.slave)
   );

   task automatic set_in(input logic f, input logic [2:0] s0,
                         input logic [2:0] s1, input logic [3:0] m0,
                         input logic [2:0] r0);
      bif.use_fdc       = f;
      bif.slot_select   = {s1, s0};
      bif.mapper_select = {4'd0, m0};
      bif.sram_select   = {3'd0, r0};
   endtask

   task automatic rebase();
      reset = 1'b1;
      bif.reload_ack = 1'b0;
      set_in(1'b0, 3'd0, 3'd0, 4'd0, 3'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int highs;
      reset = 1'b1;
      bif.reload_ack = 1'b0;
      set_in(1'b0, 3'd0, 3'd0, 4'd0, 3'd0);
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bif.reload !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_reload got %b want 0", bif.reload);
      end
      n_cmp++;
      if (bif.changed_slots !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_changed got %b want 00",
                  bif.changed_slots);
      end
      @(negedge clk);
      reset = 1'b0;
      highs = 0;
      repeat (2000) begin
         @(negedge clk);
         if (bif.reload !== 1'b0) highs++;
      end
      n_cmp++;
      if (highs != 0) begin
         n_bad++;
         $display("FAIL idle_no_reload got %0d high cycles want 0",
                  highs);
      end
      n_cmp++;
      if (bif.cart_typ !== 6'd0) begin
         n_bad++;
         $display("FAIL idle_typ got %h want 00", bif.cart_typ);
      end
      n_cmp++;
      if (bif.rom_load_hide !== 2'b00) begin
         n_bad++;
         $display("FAIL idle_rom_hide got %b want 00",
                  bif.rom_load_hide);
      end
   endtask

   task automatic test_decode();
      dec_t tbl[11];
      dec_t e;
      tbl[0]  = '{1'b1,3'd6,3'd4,4'd0, 3'd0,6'o77,8'h22,16'h0000,2'b11,2'b11,1'b1};
      tbl[1]  = '{1'b0,3'd6,3'd4,4'd0, 3'd0,6'o76,8'h22,16'h0000,2'b11,2'b11,1'b1};
      tbl[2]  = '{1'b0,3'd5,3'd3,4'd0, 3'd0,6'o35,8'h22,16'h0000,2'b11,2'b11,1'b0};
      tbl[3]  = '{1'b0,3'd0,3'd5,4'd2, 3'd3,6'o70,8'h24,16'h0004,2'b10,2'b10,1'b0};
      tbl[4]  = '{1'b0,3'd0,3'd0,4'd1, 3'd3,6'o00,8'h23,16'h0000,2'b00,2'b10,1'b0};
      tbl[5]  = '{1'b0,3'd0,3'd0,4'd0, 3'd3,6'o00,8'h22,16'h0000,2'b00,2'b11,1'b0};
      tbl[6]  = '{1'b0,3'd0,3'd0,4'd15,3'd3,6'o00,8'h21,16'h0004,2'b00,2'b10,1'b0};
      tbl[7]  = '{1'b0,3'd0,3'd0,4'd2, 3'd6,6'o00,8'h24,16'h0020,2'b00,2'b10,1'b0};
      tbl[8]  = '{1'b0,3'd0,3'd0,4'd2, 3'd7,6'o00,8'h24,16'h0000,2'b00,2'b10,1'b0};
      tbl[9]  = '{1'b0,3'd1,3'd0,4'd2, 3'd3,6'o01,8'h24,16'h0000,2'b01,2'b11,1'b0};
      tbl[10] = '{1'b0,3'd7,3'd6,4'd0, 3'd0,6'o77,8'h22,16'h0000,2'b11,2'b11,1'b0};
      for (int n = 0; n < 11; n++) begin
         set_in(tbl[n].f, tbl[n].s0, tbl[n].s1, tbl[n].m0, tbl[n].r0);
         dec_q.push_back(tbl[n]);
         #1;
         e = dec_q.pop_front();
         n_cmp++;
         if (bif.cart_typ !== e.typ) begin
            n_bad++;
            $display("FAIL dec%0d_typ got %o want %o",
                     n, bif.cart_typ, e.typ);
         end
         n_cmp++;
         if (bif.cart_mapper !== e.map) begin
            n_bad++;
            $display("FAIL dec%0d_mapper got %h want %h",
                     n, bif.cart_mapper, e.map);
         end
         n_cmp++;
         if (bif.cart_sram_size !== e.size) begin
            n_bad++;
            $display("FAIL dec%0d_size got %h want %h",
                     n, bif.cart_sram_size, e.size);
         end
         n_cmp++;
         if (bif.rom_load_hide !== e.rh) begin
            n_bad++;
            $display("FAIL dec%0d_rom_hide got %b want %b",
                     n, bif.rom_load_hide, e.rh);
         end
         n_cmp++;
         if (bif.sram_select_hide !== e.sh) begin
            n_bad++;
            $display("FAIL dec%0d_sram_hide got %b want %b",
                     n, bif.sram_select_hide, e.sh);
         end
         n_cmp++;
         if (bif.fdc_enabled !== e.fdc) begin
            n_bad++;
            $display("FAIL dec%0d_fdc got %b want %b",
                     n, bif.fdc_enabled, e.fdc);
         end
      end
   endtask

   task automatic test_reload_latency();
      int found;
      int want;
      @(posedge clk); #1;
      set_in(1'b0, 3'd0, 3'd1, 4'd0, 3'd0);
      cyc_q.push_back(cyc + 5);
      found = 0;
      for (int n = 0; n < 20 && found == 0; n++) begin
         @(negedge clk);
         if (bif.reload === 1'b1) found = 1;
      end
      want = cyc_q.pop_front();
      n_cmp++;
      if (found == 0) begin
         n_bad++;
         $display("FAIL latency_timeout got none want edge %0d", want);
      end else if (cyc != want) begin
         n_bad++;
         $display("FAIL latency_edge got %0d want %0d", cyc, want);
      end
      n_cmp++;
      if (bif.changed_slots !== CHG_S1) begin
         n_bad++;
         $display("FAIL latency_changed got %b want %b",
                  bif.changed_slots, CHG_S1);
      end
      @(posedge clk); #1;
      bif.reload_ack = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bif.reload !== 1'b1) begin
         n_bad++;
         $display("FAIL ack_hold got %b want 1", bif.reload);
      end
      @(posedge clk); #1;
      bif.reload_ack = 1'b0;
      n_cmp++;
      if (bif.reload !== 1'b0) begin
         n_bad++;
         $display("FAIL ack_clear got %b want 0", bif.reload);
      end
      n_cmp++;
      if (bif.changed_slots !== 2'b00) begin
         n_bad++;
         $display("FAIL ack_changed got %b want 00",
                  bif.changed_slots);
      end
      found = 0;
      repeat (10) begin
         @(negedge clk);
         if (bif.reload !== 1'b0) found++;
      end
      n_cmp++;
      if (found != 0) begin
         n_bad++;
         $display("FAIL post_ack_quiet got %0d want 0", found);
      end
   endtask

   task automatic test_toggle();
      logic [2:0] v;
      int hi;
      int rises;
      int first;
      int want;
      logic prev;
      v = 3'd0;
      hi = 0;
      for (int t = 0; t < 5; t++) begin
         @(posedge clk); #1;
         v = (v == 3'd0) ? 3'd1 : 3'd0;
         set_in(1'b0, v, 3'd1, 4'd0, 3'd0);
         if (t == 4) cyc_q.push_back(cyc + 5);
         repeat (3) begin
            @(negedge clk);
            if (bif.reload !== 1'b0) hi++;
         end
      end
      n_cmp++;
      if (hi != 0) begin
         n_bad++;
         $display("FAIL toggle_quiet got %0d want 0", hi);
      end
      rises = 0;
      first = -1;
      prev = bif.reload;
      repeat (20) begin
         @(negedge clk);
         if (bif.reload === 1'b1 && prev !== 1'b1) begin
            rises++;
            if (rises == 1) first = cyc;
         end
         prev = bif.reload;
         bif.reload_ack = bif.reload;
      end
      bif.reload_ack = 1'b0;
      want = cyc_q.pop_front();
      n_cmp++;
      if (first != want) begin
         n_bad++;
         $display("FAIL toggle_edge got %0d want %0d", first, want);
      end
      n_cmp++;
      if (rises != 1) begin
         n_bad++;
         $display("FAIL toggle_count got %0d want 1", rises);
      end
   endtask

   task automatic test_ack_ignored();
      int found;
      int want;
      @(posedge clk); #1;
      bif.reload_ack = 1'b1;
      set_in(1'b0, 3'd2, 3'd1, 4'd0, 3'd0);
      cyc_q.push_back(cyc + 5);
      found = 0;
      for (int n = 0; n < 20 && found == 0; n++) begin
         @(negedge clk);
         if (bif.reload === 1'b1) found = 1;
      end
      want = cyc_q.pop_front();
      n_cmp++;
      if (found == 0 || cyc != want) begin
         n_bad++;
         $display("FAIL ack_ignored_edge got %0d (found %0d) want %0d",
                  cyc, found, want);
      end
      @(negedge clk);
      n_cmp++;
      if (bif.reload !== 1'b0) begin
         n_bad++;
         $display("FAIL ack_ignored_clear got %b want 0", bif.reload);
      end
      bif.reload_ack = 1'b0;
   endtask

   task automatic test_reset_mid_reload();
      int found;
      int highs;
      @(posedge clk); #1;
      set_in(1'b0, 3'd2, 3'd2, 4'd0, 3'd0);
      found = 0;
      for (int n = 0; n < 20 && found == 0; n++) begin
         @(negedge clk);
         if (bif.reload === 1'b1) found = 1;
      end
      n_cmp++;
      if (found == 0) begin
         n_bad++;
         $display("FAIL midrst_setup got 0 want reload 1");
      end
      n_cmp++;
      if (bif.changed_slots !== CHG_S1) begin
         n_bad++;
         $display("FAIL midrst_changed got %b want %b",
                  bif.changed_slots, CHG_S1);
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bif.reload !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_drop got %b want 0", bif.reload);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      highs = 0;
      repeat (30) begin
         @(negedge clk);
         if (bif.reload !== 1'b0) highs++;
      end
      n_cmp++;
      if (highs != 0) begin
         n_bad++;
         $display("FAIL midrst_quiet got %0d want 0", highs);
      end
      n_cmp++;
      if (bif.cart_typ !== 6'o22) begin
         n_bad++;
         $display("FAIL midrst_typ got %o want 22", bif.cart_typ);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      rebase();
      test_reload_latency();
      test_toggle();
      test_ack_ignored();
      test_reset_mid_reload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
